// File: rtl/filter_ctrl_pkg.sv
// Shared types and default geometry/timing for the VGA filter control block.
// Pure declarations: no logic, no latency, no backpressure.
package filter_ctrl_pkg;

    typedef enum logic [2:0] {
        PASS   = 3'd0,
        DIFF   = 3'd1,
        INVERT = 3'd2,
        GRAY   = 3'd3,
        EDGE   = 3'd4,
        THRESH = 3'd5
    } filter_mode_t;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } deb_state_t;

    localparam int DEF_WIDTH           = 640;
    localparam int DEF_HEIGHT          = 480;
    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_NUM_MODES       = 6;
    localparam int DEF_AUTO_FRAMES     = 60;

endpackage

// File: rtl/key_debounce.sv
// Push-button debouncer: emits a one-cycle press pulse once a low level has been stable.
// Pulse is registered (one cycle after the qualifying sample); no backpressure.
module key_debounce
    import filter_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic VGA_CLK,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    deb_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;

    always_ff @(posedge VGA_CLK) begin
        if (!reset_n) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (!key_n) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (key_n) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else if (cnt_q == LAST) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                PRESSED: begin
                    if (key_n) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back low re-enters PRESSED silently: still the same press.
                    if (!key_n) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == LAST) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= RELEASED;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign press = press_q;

endmodule

// File: rtl/filter_mode_ctrl.sv
// Filter mode/channel control: debounced key stepping, auto-cycle, vsync-aligned commit, pixel position.
// Config commits on the cycle after the VS fall is sampled; pix_x/pix_y lag the pixel by one cycle; no backpressure.
module filter_mode_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int HEIGHT          = DEF_HEIGHT,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int NUM_MODES       = DEF_NUM_MODES,
    parameter int AUTO_FRAMES     = DEF_AUTO_FRAMES
) (
    input  logic        VGA_CLK,
    input  logic        reset_n,
    input  logic        iVGA_VS,
    input  logic        iVGA_BLANK_N,
    input  logic [1:0]  KEY,
    input  logic [8:0]  SW,
    output logic [2:0]  mode,
    output logic [2:0]  chan_en,
    output logic        cfg_update,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] frame_cnt,
    output logic        pos_err
);

    localparam int AW = $clog2(AUTO_FRAMES + 1);

    function automatic logic [2:0] mode_inc(input logic [2:0] m);
        return (m == 3'(NUM_MODES - 1)) ? 3'd0 : m + 3'd1;
    endfunction

    function automatic logic [2:0] mode_dec(input logic [2:0] m);
        return (m == 3'd0) ? 3'(NUM_MODES - 1) : m - 3'd1;
    endfunction

    logic [1:0] key_s1_q, key_s2_q;
    logic [3:0] sw_s1_q, sw_s2_q;     // {auto enable, R, G, B}
    logic       sw_unused;
    logic       up_press, dn_press;

    logic          vs_prev_q, vs_prev_d;
    logic          blank_prev_q, blank_prev_d;
    logic [2:0]    pend_q, pend_d;
    logic [2:0]    mode_q, mode_d;
    logic [2:0]    chan_q, chan_d;
    logic          cfg_q, cfg_d;
    logic [AW-1:0] auto_q, auto_d;
    logic [15:0]   frame_q, frame_d;
    logic [9:0]    px_q, px_d;
    logic [8:0]    py_q, py_d;
    logic          lines_full_q, lines_full_d;
    logic          err_q, err_d;

    logic       commit, auto_step;
    logic [2:0] pend_base;

    assign sw_unused = ^SW[7:3];

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .VGA_CLK (VGA_CLK),
        .reset_n (reset_n),
        .key_n   (key_s2_q[0]),
        .press   (up_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
        .VGA_CLK (VGA_CLK),
        .reset_n (reset_n),
        .key_n   (key_s2_q[1]),
        .press   (dn_press)
    );

    always_comb begin
        vs_prev_d    = iVGA_VS;
        blank_prev_d = iVGA_BLANK_N;
        mode_d       = mode_q;
        chan_d       = chan_q;
        cfg_d        = 1'b0;
        auto_d       = auto_q;
        frame_d      = frame_q;
        px_d         = px_q;
        py_d         = py_q;
        lines_full_d = lines_full_q;
        err_d        = err_q;

        commit    = vs_prev_q & ~iVGA_VS;
        auto_step = commit && sw_s2_q[3] && (auto_q == AW'(AUTO_FRAMES - 1));
        pend_base = auto_step ? mode_inc(pend_q) : pend_q;

        // Presses on the commit cycle stack on top of pend_base and wait for the next frame.
        if (up_press && !dn_press)
            pend_d = mode_inc(pend_base);
        else if (dn_press && !up_press)
            pend_d = mode_dec(pend_base);
        else
            pend_d = pend_base;

        if (!sw_s2_q[3])
            auto_d = '0;
        else if (commit)
            auto_d = auto_step ? '0 : auto_q + AW'(1);

        if (commit) begin
            mode_d  = pend_base;
            chan_d  = sw_s2_q[2:0];
            frame_d = frame_q + 16'd1;
            cfg_d   = (pend_base != mode_q) || (sw_s2_q[2:0] != chan_q);
        end

        if (!iVGA_VS) begin
            px_d         = '0;
            py_d         = '0;
            lines_full_d = 1'b0;
        end else if (iVGA_BLANK_N) begin
            if (lines_full_q)
                err_d = 1'b1;
            if (!blank_prev_q)
                px_d = '0;
            else if (px_q == 10'(WIDTH - 1))
                err_d = 1'b1;
            else
                px_d = px_q + 10'd1;
        end else if (blank_prev_q) begin
            px_d = '0;
            if (py_q == 9'(HEIGHT - 1))
                lines_full_d = 1'b1;
            else
                py_d = py_q + 9'd1;
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (!reset_n) begin
            key_s1_q     <= 2'b11;
            key_s2_q     <= 2'b11;
            sw_s1_q      <= '0;
            sw_s2_q      <= '0;
            vs_prev_q    <= 1'b0;
            blank_prev_q <= 1'b0;
            pend_q       <= PASS;
            mode_q       <= PASS;
            chan_q       <= '0;
            cfg_q        <= 1'b0;
            auto_q       <= '0;
            frame_q      <= '0;
            px_q         <= '0;
            py_q         <= '0;
            lines_full_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            key_s1_q     <= KEY;
            key_s2_q     <= key_s1_q;
            sw_s1_q      <= {SW[8], SW[2:0]};
            sw_s2_q      <= sw_s1_q;
            vs_prev_q    <= vs_prev_d;
            blank_prev_q <= blank_prev_d;
            pend_q       <= pend_d;
            mode_q       <= mode_d;
            chan_q       <= chan_d;
            cfg_q        <= cfg_d;
            auto_q       <= auto_d;
            frame_q      <= frame_d;
            px_q         <= px_d;
            py_q         <= py_d;
            lines_full_q <= lines_full_d;
            err_q        <= err_d;
        end
    end

    assign mode       = mode_q;
    assign chan_en    = chan_q;
    assign cfg_update = cfg_q;
    assign pix_x      = px_q;
    assign pix_y      = py_q;
    assign frame_cnt  = frame_q;
    assign pos_err    = err_q;

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// Directed + randomized bench for filter_mode_ctrl with small geometry and short debounce.
// Expected values come from an arithmetic model of presses, auto steps and frame geometry.
module tb_filter_mode_ctrl;

    localparam int W  = 10;
    localparam int H  = 10;
    localparam int DB = 4;
    localparam int NM = 6;
    localparam int AF = 3;

    logic        VGA_CLK = 1'b0;
    logic        reset_n;
    logic        iVGA_VS;
    logic        iVGA_BLANK_N;
    logic [1:0]  KEY;
    logic [8:0]  SW;
    logic [2:0]  mode;
    logic [2:0]  chan_en;
    logic        cfg_update;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [15:0] frame_cnt;
    logic        pos_err;

    filter_mode_ctrl #(
        .WIDTH(W), .HEIGHT(H), .DEBOUNCE_CYCLES(DB), .NUM_MODES(NM), .AUTO_FRAMES(AF)
    ) dut (
        .VGA_CLK      (VGA_CLK),
        .reset_n      (reset_n),
        .iVGA_VS      (iVGA_VS),
        .iVGA_BLANK_N (iVGA_BLANK_N),
        .KEY          (KEY),
        .SW           (SW),
        .mode         (mode),
        .chan_en      (chan_en),
        .cfg_update   (cfg_update),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .frame_cnt    (frame_cnt),
        .pos_err      (pos_err)
    );

    always #20 VGA_CLK = ~VGA_CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int exp_pend, exp_mode, exp_chan, exp_frame, auto_commits;
    int exp_err;

    task automatic step();
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic do_reset();
        reset_n      = 1'b0;
        KEY          = 2'b11;
        iVGA_VS      = 1'b1;
        iVGA_BLANK_N = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        exp_pend = 0; exp_mode = 0; exp_chan = 0; exp_frame = 0;
        auto_commits = 0; exp_err = 0;
        chk("rst_mode", mode, 0);
        chk("rst_chan", chan_en, 0);
        chk("rst_cfg", cfg_update, 0);
        chk("rst_px", pix_x, 0);
        chk("rst_py", pix_y, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_err", pos_err, 0);
    endtask

    // which[0] = up key, which[1] = down key; both together cancel
    task automatic press_keys(input logic [1:0] which);
        KEY = ~which;
        repeat (10) step();
        KEY = 2'b11;
        repeat (10) step();
        if (which == 2'b01) exp_pend = (exp_pend + 1) % NM;
        if (which == 2'b10) exp_pend = (exp_pend + NM - 1) % NM;
    endtask

    task automatic vsync();
        int new_chan;
        int exp_cfg;
        repeat (4) step();
        chk("mode_hold", mode, exp_mode);
        chk("chan_hold", chan_en, exp_chan);
        if (SW[8]) begin
            auto_commits++;
            if (auto_commits % AF == 0) exp_pend = (exp_pend + 1) % NM;
        end else begin
            auto_commits = 0;
        end
        new_chan  = int'(SW[2:0]);
        exp_cfg   = ((exp_pend != exp_mode) || (new_chan != exp_chan)) ? 1 : 0;
        exp_mode  = exp_pend;
        exp_chan  = new_chan;
        exp_frame = (exp_frame + 1) % 65536;
        iVGA_BLANK_N = 1'b0;
        iVGA_VS      = 1'b0;
        step();
        chk("commit_mode", mode, exp_mode);
        chk("commit_chan", chan_en, exp_chan);
        chk("commit_cfg", cfg_update, exp_cfg);
        chk("commit_frame", frame_cnt, exp_frame);
        chk("vs_px", pix_x, 0);
        chk("vs_py", pix_y, 0);
        step();
        chk("cfg_one_cycle", cfg_update, 0);
        repeat (3) step();
        iVGA_VS = 1'b1;
        step();
    endtask

    // nlines active lines; line index long_line carries W+1 pixels
    task automatic frame_lines(input int nlines, input int long_line);
        int npix;
        iVGA_VS = 1'b1;
        step();
        for (int l = 0; l < nlines; l++) begin
            npix = (l == long_line) ? W + 1 : W;
            iVGA_BLANK_N = 1'b1;
            for (int i = 0; i < npix; i++) begin
                step();
                chk("px", pix_x, min_i(i, W - 1));
                chk("py", pix_y, min_i(l, H - 1));
                if (l >= H || i >= W) exp_err = 1;
            end
            iVGA_BLANK_N = 1'b0;
            step();
            chk("px_eol", pix_x, 0);
            chk("py_eol", pix_y, min_i(l + 1, H - 1));
            chk("pos_err", pos_err, exp_err);
            repeat (2) step();
        end
        vsync();
    endtask

    initial begin
        SW = '0;
        do_reset();

        // Idle frames: nothing changes, frame counter reaches 2
        vsync();
        vsync();
        chk("frame_after_2", frame_cnt, 2);

        // Short glitch ignored, then a real up press
        KEY = 2'b10;
        repeat (3) step();
        KEY = 2'b11;
        repeat (10) step();
        press_keys(2'b01);
        chk("mode_before_vs", mode, 0);
        vsync();

        // Down wraps below zero; many ups accumulate in one frame
        press_keys(2'b10);
        vsync();
        press_keys(2'b10);
        vsync();
        chk("mode_wrap_down", mode, NM - 1);
        for (int k = 0; k < 7; k++) press_keys(2'b01);
        vsync();

        // Simultaneous presses cancel; channel switch takes effect at vsync only
        press_keys(2'b11);
        vsync();
        SW[2:0] = 3'b101;
        repeat (6) step();
        chk("chan_midframe", chan_en, 0);
        vsync();

        // Auto-cycle then frozen
        SW[8] = 1'b1;
        repeat (7) vsync();
        SW[8] = 1'b0;
        repeat (3) vsync();

        // Geometry: clean frame, too many lines, too long a line
        frame_lines(H, -1);
        frame_lines(H + 1, -1);
        do_reset();
        frame_lines(H, 3);
        frame_lines(H, -1);
        chk("err_sticky", pos_err, 1);
        do_reset();

        // Randomized frames: random switches and key activity
        for (int it = 0; it < 12; it++) begin
            int n;
            SW = 9'($urandom);
            if ($urandom_range(0, 2) != 0) SW[8] = 1'b0;
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) press_keys(2'($urandom_range(1, 3)));
            vsync();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
